// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory handshake, instruction register
// outputs toward decode/datapath, and PC redirect from execute.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_instr;
  logic [31:0] ir_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, ir_valid, ir_instr, ir_pc, opcode, func3, misalign_err,
    input  imem_rvalid, imem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_instr, ir_pc, opcode, func3, misalign_err,
    output imem_rvalid, imem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction fetch at a time, holds the
// result in an instruction register and handles branch/jump redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                  clk,
  input logic                  rst,
  instr_fetch_unit_if.master   fetch_if
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] fetch_addr_q;
  logic [31:0] ir_instr_q;
  logic [31:0] ir_pc_q;
  logic        ir_valid_q;
  logic        misalign_err_q;
  logic        req_q;

  logic        redir_ok_d;
  logic        redir_bad_d;

  assign redir_ok_d  = fetch_if.redirect && (fetch_if.redirect_pc[1:0] == 2'b00);
  assign redir_bad_d = fetch_if.redirect && (fetch_if.redirect_pc[1:0] != 2'b00);

  // A misaligned redirect from any live state abandons everything and parks
  // in HALT; only rst recovers, and pc is deliberately left untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      fetch_addr_q   <= RESET_PC;
      ir_instr_q     <= NOP_INSTR;
      ir_pc_q        <= RESET_PC;
      ir_valid_q     <= 1'b0;
      misalign_err_q <= 1'b0;
      req_q          <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          fetch_addr_q <= pc_q;
          req_q        <= 1'b1;
          state_q      <= FETCH;
        end

        FETCH: begin
          if (redir_bad_d) begin
            misalign_err_q <= 1'b1;
            ir_valid_q     <= 1'b0;
            ir_instr_q     <= NOP_INSTR;
            req_q          <= 1'b0;
            state_q        <= HALT;
          end else if (redir_ok_d && fetch_if.imem_rvalid) begin
            pc_q         <= fetch_if.redirect_pc;
            fetch_addr_q <= fetch_if.redirect_pc;
          end else if (redir_ok_d) begin
            pc_q    <= fetch_if.redirect_pc;
            state_q <= DRAIN;
          end else if (fetch_if.imem_rvalid) begin
            ir_instr_q <= fetch_if.imem_rdata;
            ir_pc_q    <= fetch_addr_q;
            ir_valid_q <= 1'b1;
            pc_q       <= fetch_addr_q + 32'd4;
            req_q      <= 1'b0;
            state_q    <= HOLD;
          end
        end

        // The stale response still has to arrive; the newest target wins.
        DRAIN: begin
          if (redir_bad_d) begin
            misalign_err_q <= 1'b1;
            ir_valid_q     <= 1'b0;
            ir_instr_q     <= NOP_INSTR;
            req_q          <= 1'b0;
            state_q        <= HALT;
          end else begin
            if (redir_ok_d) begin
              pc_q <= fetch_if.redirect_pc;
            end
            if (fetch_if.imem_rvalid) begin
              fetch_addr_q <= redir_ok_d ? fetch_if.redirect_pc : pc_q;
              state_q      <= FETCH;
            end
          end
        end

        HOLD: begin
          if (redir_bad_d) begin
            misalign_err_q <= 1'b1;
            ir_valid_q     <= 1'b0;
            ir_instr_q     <= NOP_INSTR;
            req_q          <= 1'b0;
            state_q        <= HALT;
          end else if (redir_ok_d) begin
            pc_q         <= fetch_if.redirect_pc;
            fetch_addr_q <= fetch_if.redirect_pc;
            ir_valid_q   <= 1'b0;
            ir_instr_q   <= NOP_INSTR;
            req_q        <= 1'b1;
            state_q      <= FETCH;
          end else if (ir_valid_q && fetch_if.ir_ready) begin
            ir_valid_q   <= 1'b0;
            fetch_addr_q <= pc_q;
            req_q        <= 1'b1;
            state_q      <= FETCH;
          end
        end

        HALT: begin
          req_q      <= 1'b0;
          ir_valid_q <= 1'b0;
        end

        default: begin
          req_q   <= 1'b0;
          state_q <= HALT;
        end
      endcase
    end
  end

  assign fetch_if.imem_req     = req_q;
  assign fetch_if.imem_addr    = fetch_addr_q;
  assign fetch_if.ir_valid     = ir_valid_q;
  assign fetch_if.ir_instr     = ir_instr_q;
  assign fetch_if.ir_pc        = ir_pc_q;
  assign fetch_if.opcode       = ir_instr_q[6:0];
  assign fetch_if.func3        = ir_instr_q[14:12];
  assign fetch_if.misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: boot fetch, backpressure,
// redirects from FETCH and HOLD, PC wrap, misaligned halt and reset recovery.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rvalid, input logic [31:0] rdata,
                               input logic ready, input logic redir,
                               input logic [31:0] rpc);
    bus.imem_rvalid = rvalid;
    bus.imem_rdata  = rdata;
    bus.ir_ready    = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Reset state
    checkOutput("rst_req",      {31'b0, bus.imem_req},     32'd0);
    checkOutput("rst_addr",     bus.imem_addr,             RESET_PC);
    checkOutput("rst_irvalid",  {31'b0, bus.ir_valid},     32'd0);
    checkOutput("rst_irinstr",  bus.ir_instr,              NOP_INSTR);
    checkOutput("rst_irpc",     bus.ir_pc,                 RESET_PC);
    checkOutput("rst_opcode",   {25'b0, bus.opcode},       32'h13);
    checkOutput("rst_func3",    {29'b0, bus.func3},        32'd0);
    checkOutput("rst_misalign", {31'b0, bus.misalign_err}, 32'd0);

    // Cycle 0 is BOOT; request from cycle 1; L=1 response in cycle 2
    rst = 1'b0;
    checkOutput("boot_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    checkOutput("c1_req",  {31'b0, bus.imem_req}, 32'd1);
    checkOutput("c1_addr", bus.imem_addr,         32'h0040_0000);
    step();
    applyStimulus(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    checkOutput("c2_irvalid", {31'b0, bus.ir_valid}, 32'd0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("c3_irvalid", {31'b0, bus.ir_valid}, 32'd1);
    checkOutput("c3_irinstr", bus.ir_instr,          32'h0050_0093);
    checkOutput("c3_opcode",  {25'b0, bus.opcode},   32'h13);
    checkOutput("c3_func3",   {29'b0, bus.func3},    32'd0);
    checkOutput("c3_irpc",    bus.ir_pc,             32'h0040_0000);
    checkOutput("c3_req",     {31'b0, bus.imem_req}, 32'd0);

    // Backpressure: five cycles with ir_ready low
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_irvalid", {31'b0, bus.ir_valid}, 32'd1);
      checkOutput("bp_irinstr", bus.ir_instr,          32'h0050_0093);
      checkOutput("bp_req",     {31'b0, bus.imem_req}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("next_req",     {31'b0, bus.imem_req}, 32'd1);
    checkOutput("next_addr",    bus.imem_addr,         32'h0040_0004);
    checkOutput("next_irvalid", {31'b0, bus.ir_valid}, 32'd0);

    // Redirect while fetch outstanding, memory latency 3
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0100);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("drain1_addr", bus.imem_addr,         32'h0040_0004);
    checkOutput("drain1_req",  {31'b0, bus.imem_req}, 32'd1);
    step();
    checkOutput("drain2_addr", bus.imem_addr,         32'h0040_0004);
    step();
    checkOutput("drain3_addr", bus.imem_addr,         32'h0040_0004);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_addr",    bus.imem_addr,         32'h0040_0100);
    checkOutput("redir_req",     {31'b0, bus.imem_req}, 32'd1);
    checkOutput("redir_irvalid", {31'b0, bus.ir_valid}, 32'd0);

    // Fetch lw x3,2(x1) at the redirect target
    step();
    applyStimulus(1'b1, 32'h0020_A183, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("lw_irvalid", {31'b0, bus.ir_valid}, 32'd1);
    checkOutput("lw_irpc",    bus.ir_pc,             32'h0040_0100);
    checkOutput("lw_opcode",  {25'b0, bus.opcode},   32'h03);
    checkOutput("lw_func3",   {29'b0, bus.func3},    32'd2);

    // Redirect in HOLD together with ir_ready: redirect wins
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0200);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("hold_redir_irvalid", {31'b0, bus.ir_valid}, 32'd0);
    checkOutput("hold_redir_addr",    bus.imem_addr,         32'h0040_0200);
    checkOutput("hold_redir_req",     {31'b0, bus.imem_req}, 32'd1);
    checkOutput("hold_redir_irinstr", bus.ir_instr,          NOP_INSTR);

    // Redirect coinciding with the response: data dropped, refetch at once
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("same_addr",    bus.imem_addr,         32'hFFFF_FFFC);
    checkOutput("same_req",     {31'b0, bus.imem_req}, 32'd1);
    checkOutput("same_irvalid", {31'b0, bus.ir_valid}, 32'd0);
    step();
    applyStimulus(1'b1, 32'h0000_1063, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_irpc",   bus.ir_pc,           32'hFFFF_FFFC);
    checkOutput("wrap_opcode", {25'b0, bus.opcode}, 32'h63);
    checkOutput("wrap_func3",  {29'b0, bus.func3},  32'd1);

    // Stray rvalid without a request is ignored
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("stray_irinstr", bus.ir_instr,          32'h0000_1063);
    checkOutput("stray_irvalid", {31'b0, bus.ir_valid}, 32'd1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", bus.imem_addr,         32'h0000_0000);
    checkOutput("wrap_req",  {31'b0, bus.imem_req}, 32'd1);

    // Misaligned redirect halts the unit
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0102);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("mis_err",     {31'b0, bus.misalign_err}, 32'd1);
    checkOutput("mis_req",     {31'b0, bus.imem_req},     32'd0);
    checkOutput("mis_irvalid", {31'b0, bus.ir_valid},     32'd0);
    checkOutput("mis_irinstr", bus.ir_instr,              NOP_INSTR);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h0000_0033, 1'b1, (i == 2), 32'h0040_0300);
      step();
      checkOutput("halt_req",     {31'b0, bus.imem_req},     32'd0);
      checkOutput("halt_irvalid", {31'b0, bus.ir_valid},     32'd0);
      checkOutput("halt_err",     {31'b0, bus.misalign_err}, 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset recovers and fetch restarts at RESET_PC
    rst = 1'b1;
    #1;
    checkOutput("rerst_err",  {31'b0, bus.misalign_err}, 32'd0);
    checkOutput("rerst_req",  {31'b0, bus.imem_req},     32'd0);
    checkOutput("rerst_addr", bus.imem_addr,             RESET_PC);
    rst = 1'b0;
    step();
    checkOutput("restart_req",  {31'b0, bus.imem_req}, 32'd1);
    checkOutput("restart_addr", bus.imem_addr,         RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the single-cycle/multicycle RISC-V core. It owns the program counter, fetches one instruction at a time from instruction memory over a req/rvalid handshake, and holds it in an instruction register. The register feeds opcode/func3 to the control unit and the full word and PC to the datapath. It accepts PC redirects (branches, JAL, JALR) from the execute side, flushing or draining in-flight work.

## Interface
- RESET_PC, 32'h0040_0000: PC value after reset.
- NOP_INSTR, 32'h0000_0013: ir_instr value after reset and after any flush (addi x0,x0,0).
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- imem_req  out  1  fetch request; Moore output of FSM.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_rvalid  in  1  response valid; completes the outstanding request.
- imem_rdata  in  32  instruction word; sampled only when imem_rvalid=1.
- ir_valid  out  1  instruction register holds a live instruction.
- ir_ready  in  1  downstream consumes the instruction this cycle.
- ir_instr  out  32  registered instruction word.
- ir_pc  out  32  PC of ir_instr.
- opcode  out  7  ir_instr[6:0] (to control unit).
- func3  out  3  ir_instr[14:12] (to control unit).
- redirect  in  1  load new PC this cycle (taken branch/jump).
- redirect_pc  in  32  target PC; must be word aligned.
- misalign_err  out  1  sticky: a misaligned redirect was received.

## Operation
- Registers: pc, fetch_addr, ir_instr, ir_pc, ir_valid, misalign_err, state.
- Reset values: state=BOOT, pc=RESET_PC, fetch_addr=RESET_PC, ir_instr=NOP_INSTR, ir_pc=RESET_PC, ir_valid=0, misalign_err=0. imem_req=0 and imem_addr=RESET_PC while in BOOT.
- imem_req=1 in FETCH and DRAIN. It is 0 in BOOT, HOLD and HALT. imem_addr=fetch_addr at all times.
- BOOT: go to FETCH unconditionally; fetch_addr<=pc.
- FETCH: one request is outstanding at fetch_addr.
  - On imem_rvalid without redirect: ir_instr<=imem_rdata, ir_pc<=fetch_addr, ir_valid<=1, pc<=fetch_addr+4. Go to HOLD.
  - On redirect without imem_rvalid: pc<=redirect_pc and go to DRAIN.
  - On redirect together with imem_rvalid: the data is discarded, ir_valid stays 0, pc<=redirect_pc, fetch_addr<=redirect_pc, and the FSM stays in FETCH.
- DRAIN: imem_req stays high with the old fetch_addr until imem_rvalid. The response is discarded, then fetch_addr<=pc and the FSM goes to FETCH. A further redirect in DRAIN only updates pc; the newest target wins.
- HOLD: ir_valid=1, no request. On ir_valid&&ir_ready: ir_valid<=0, fetch_addr<=pc, go to FETCH.
- Redirect in HOLD: pc<=redirect_pc, fetch_addr<=redirect_pc, ir_valid<=0, ir_instr<=NOP_INSTR, go to FETCH. Redirect has priority over a simultaneous ir_ready; the held instruction counts as consumed.
- Misaligned redirect (redirect=1, redirect_pc[1:0]!=0), in any state except BOOT:
  - misalign_err<=1, ir_valid<=0, ir_instr<=NOP_INSTR, go to HALT; pc is not updated.
  - If a request is outstanding, HALT still keeps imem_req=0. Memory must tolerate an abandoned request.
  - HALT is left only by rst.
- Redirect in BOOT is ignored.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag.
- imem_rvalid while imem_req=0 is ignored.
- opcode and func3 are combinational slices of ir_instr, so their reset and flush value is 7'h13 / 3'h0.

## Timing
- Reset release at edge 0: BOOT for cycle 0, imem_req=1 from cycle 1.
- Memory latency L≥1 cycles: rvalid in cycle t gives ir_valid=1 in cycle t+1.
- Handshake in cycle m gives imem_req=1 in cycle m+1. Best-case throughput is one instruction per L+2 cycles.
- Redirect in cycle r from HOLD: imem_addr=redirect_pc in cycle r+1.
- Redirect in cycle r from FETCH: the new fetch starts the cycle after the old response arrives.
- rst assertion mid-transaction returns all registers to reset values immediately (asynchronous), including a pending request.

## Test plan
- Reset, memory L=1 returning 32'h00500093 at 0x00400000 → imem_req rises cycle 1, ir_valid cycle 3, opcode=7'h13, func3=0, ir_pc=0x00400000; after ir_ready, next imem_addr=0x00400004.
- Backpressure: ir_ready=0 for 5 cycles → ir_valid, ir_instr stable, imem_req=0 throughout; release → one fetch at next PC.
- Redirect to 0x00400100 while FETCH outstanding with L=3 → imem_addr stays old until rvalid, data dropped, ir_valid stays 0, next request at 0x00400100.
- Redirect to 0x00400200 simultaneous with ir_ready in HOLD → ir_valid 0 next cycle, imem_addr=0x00400200, no fetch at the old pc+4.
- Redirect to 0x00400102 → misalign_err=1, imem_req=0, ir_valid=0 forever; rst clears and fetch restarts at RESET_PC.
- Wrap: redirect to 0xFFFFFFFC, consume → next fetch address 0x00000000.
